// File: rtl/time_set_controller.sv
// Key debouncing, auto-repeat and the set-time state machine.
// Edits shadow h/m/s values and strobes them into the counters on commit.
module time_set_controller #(
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_RATE     = 100000,
  parameter int TIMEOUT         = 16000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_mode,
  input  logic       key_up,
  input  logic       key_down,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_minute,
  input  logic [5:0] cur_second,
  output logic       set_active,
  output logic [1:0] set_field,
  output logic [4:0] set_hour,
  output logic [5:0] set_minute,
  output logic [5:0] set_second,
  output logic       load
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, SET_HOUR, SET_MINUTE, SET_SECOND, COMMIT
  } state_t;

  // bit 0 mode, bit 1 up, bit 2 down
  logic [2:0]    raw, sync1, sync2, stable, stable_d, press;
  logic [DW-1:0] dcnt [3];

  assign raw   = {key_down, key_up, key_mode};
  assign press = stable & ~stable_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      for (int k = 0; k < 3; k++) dcnt[k] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable;
      for (int k = 0; k < 3; k++) begin
        if (sync2[k] == stable[k]) begin
          dcnt[k] <= '0;
        end else if (dcnt[k] == DW'(DEBOUNCE_CYCLES - 1)) begin
          dcnt[k]   <= '0;
          stable[k] <= sync2[k];
        end else begin
          dcnt[k] <= dcnt[k] + DW'(1);
        end
      end
    end
  end

  // auto-repeat, bit 0 up, bit 1 down
  logic [1:0]    rep_on, rep_hit, step;
  logic [RW-1:0] rcnt [2];

  always_comb begin
    rep_hit = '0;
    for (int k = 0; k < 2; k++) begin
      rep_hit[k] = stable[k+1] &
        (rep_on[k] ? (rcnt[k] == RW'(REPEAT_RATE))
                   : (rcnt[k] == RW'(REPEAT_DELAY)));
    end
  end

  assign step = press[2:1] | rep_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      rep_on <= '0;
      for (int k = 0; k < 2; k++) rcnt[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (press[k+1]) begin
          rcnt[k]   <= RW'(1);
          rep_on[k] <= 1'b0;
        end else if (!stable[k+1]) begin
          rcnt[k]   <= '0;
          rep_on[k] <= 1'b0;
        end else if (rep_hit[k]) begin
          rcnt[k]   <= RW'(1);
          rep_on[k] <= 1'b1;
        end else begin
          rcnt[k] <= rcnt[k] + RW'(1);
        end
      end
    end
  end

  state_t        state, state_n;
  logic          mode_p, inc, dec, act, in_set, t_hit;
  logic [TW-1:0] tcnt;
  logic [4:0]    hour_n;
  logic [5:0]    min_n, sec_n;
  logic [1:0]    field_n;

  // mode wins over a step; opposing steps cancel
  assign mode_p = press[0];
  assign inc    = step[0] & ~step[1] & ~mode_p;
  assign dec    = step[1] & ~step[0] & ~mode_p;
  assign act    = mode_p | step[0] | step[1];
  assign in_set = (state == SET_HOUR) | (state == SET_MINUTE) |
                  (state == SET_SECOND);
  assign t_hit  = in_set & ~act & (tcnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_n = state;
    hour_n  = set_hour;
    min_n   = set_minute;
    sec_n   = set_second;
    field_n = 2'd0;
    unique case (state)
      IDLE: begin
        if (mode_p) begin
          state_n = SET_HOUR;
          hour_n  = cur_hour;
          min_n   = cur_minute;
          sec_n   = cur_second;
        end
      end
      SET_HOUR: begin
        if (mode_p) state_n = SET_MINUTE;
        else if (t_hit) state_n = IDLE;
        if (inc) hour_n = (set_hour == 5'd23) ? 5'd0 : set_hour + 5'd1;
        else if (dec) hour_n = (set_hour == 5'd0) ? 5'd23 : set_hour - 5'd1;
      end
      SET_MINUTE: begin
        if (mode_p) state_n = SET_SECOND;
        else if (t_hit) state_n = IDLE;
        if (inc) min_n = (set_minute == 6'd59) ? 6'd0 : set_minute + 6'd1;
        else if (dec) min_n = (set_minute == 6'd0) ? 6'd59 : set_minute - 6'd1;
      end
      SET_SECOND: begin
        if (mode_p) state_n = COMMIT;
        else if (t_hit) state_n = IDLE;
        if (inc) sec_n = (set_second == 6'd59) ? 6'd0 : set_second + 6'd1;
        else if (dec) sec_n = (set_second == 6'd0) ? 6'd59 : set_second - 6'd1;
      end
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    unique case (state_n)
      SET_HOUR:   field_n = 2'd1;
      SET_MINUTE: field_n = 2'd2;
      SET_SECOND: field_n = 2'd3;
      default:    field_n = 2'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      set_hour   <= '0;
      set_minute <= '0;
      set_second <= '0;
      set_field  <= '0;
      set_active <= 1'b0;
      load       <= 1'b0;
      tcnt       <= '0;
    end else begin
      state      <= state_n;
      set_hour   <= hour_n;
      set_minute <= min_n;
      set_second <= sec_n;
      set_field  <= field_n;
      set_active <= (field_n != 2'd0);
      load       <= (state_n == COMMIT);
      tcnt       <= (act | ~in_set) ? '0 : tcnt + TW'(1);
    end
  end

endmodule

// File: doc/time_set_controller.md
Name: time_set_controller

Overview:
- User-input side of the clock: debounces the mode/up/down push-buttons and runs a set-time state machine.
- Edits shadow hour/minute/second values that the display path shows while setting is active.
- Issues a one-cycle load strobe that writes the edited time into the hour/minute/second counters.
- Sits between the raw ui_in key pins and the timekeeping counters, alongside segment_show.

Parameters:
- DEBOUNCE_CYCLES, 1024: consecutive stable cycles required before a key level is accepted.
- REPEAT_DELAY, 500000: cycles a debounced up/down key must be held before auto-repeat starts.
- REPEAT_RATE, 100000: cycles between auto-repeat steps once repeat has started.
- TIMEOUT, 16000000: cycles with no accepted key press in a set state before setting is abandoned.

Ports:
- clock  input  1  system clock, the only clock.
- reset  input  1  synchronous, active-high reset.
- key_mode  input  1  raw mode button, active high, asynchronous to clock.
- key_up  input  1  raw increment button, active high.
- key_down  input  1  raw decrement button, active high.
- cur_hour  input  5  live hour, 0..23.
- cur_minute  input  6  live minute, 0..59.
- cur_second  input  6  live second, 0..59.
- set_active  output  1  high in any SET_* state; the display shows the set_* values.
- set_field  output  2  field being edited: 0 none, 1 hour, 2 minute, 3 second.
- set_hour  output  5  shadow hour.
- set_minute  output  6  shadow minute.
- set_second  output  6  shadow second.
- load  output  1  one-cycle strobe; the counters take the set_* values on this cycle.

Behaviour:
- Reset (sampled on the clock edge): state IDLE.
  - Outputs: set_active=0, set_field=0, set_hour=0, set_minute=0, set_second=0, load=0.
  - All synchronisers, debounce counters, repeat counters and the timeout counter are cleared.
  - Reset asserted mid-edit discards the edit; no load is issued.
- Input path, per key:
  - Two-flop synchroniser.
  - Debounce counter: the stable level flips only after the synchronised value differs from it for DEBOUNCE_CYCLES consecutive cycles. Any glitch restarts the count.
  - Press event: one-cycle pulse on a stable 0->1 transition.
  - Latency: raw key held high from cycle t produces the press pulse at cycle t+2+DEBOUNCE_CYCLES.
- Auto-repeat (up/down only):
  - While the stable level stays high, an extra step pulse fires REPEAT_DELAY cycles after the press pulse, then every REPEAT_RATE cycles.
  - Release stops repeat immediately.
- Step precedence: if up and down step pulses coincide, neither is applied. A mode press in the same cycle as a step wins, and the step is dropped.
- FSM states: IDLE, SET_HOUR, SET_MINUTE, SET_SECOND, COMMIT.
  - IDLE + mode press -> SET_HOUR. On the same edge, set_hour/set_minute/set_second capture cur_hour/cur_minute/cur_second.
  - SET_HOUR + mode -> SET_MINUTE.
  - SET_MINUTE + mode -> SET_SECOND.
  - SET_SECOND + mode -> COMMIT.
  - COMMIT: load=1 for exactly this one cycle, then IDLE unconditionally. set_* hold their values.
  - Up/down press events in IDLE or COMMIT are ignored.
- set_field: 1/2/3 in SET_HOUR/SET_MINUTE/SET_SECOND, 0 otherwise. set_active=1 exactly when set_field!=0.
- Field arithmetic, on the field selected by state:
  - Up: hour 23->0, minute/second 59->0, otherwise +1.
  - Down: 0->23 (hour) or 0->59 (minute/second), otherwise -1.
  - Result is registered; visible the cycle after the step pulse.
- Timeout:
  - Counter clears on every accepted mode/up/down pulse (including repeat steps) and on entry to SET_HOUR.
  - Reaching TIMEOUT in any SET_* state -> IDLE with no load; set_* keep their last values.
- All outputs are registered.

Test Plan (bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=16, REPEAT_RATE=4, TIMEOUT=64):
- Debounce: key_mode toggles high/low every 2 cycles for 20 cycles, then held high at cycle t.
  - Required: no FSM change during the glitches; set_field=1 at cycle t+7; set_hour/minute/second equal cur_* = 13/45/30.
- Wrap: in SET_HOUR from 23, one up press -> set_hour=0. In SET_MINUTE from 0, one down press -> set_minute=59.
- Auto-repeat: in SET_SECOND from 10, key_up held 40 cycles past its press pulse.
  - Required: steps at press, +16, +20, +24, +28, +32, +36, +40 -> set_second=18; release stops further steps.
- Full commit: mode x4 with edits to 07:08:09.
  - Required: load high exactly one cycle with set_hour=7, set_minute=8, set_second=9; then set_field=0, set_active=0.
- Conflicts: up and down pressed on the same cycle -> value unchanged. Mode and up pulses coinciding -> field advances and the value is unchanged.
- Timeout/reset:
  - Idle 64 cycles in SET_MINUTE -> IDLE, load never asserts.
  - reset asserted during SET_SECOND -> next cycle all outputs 0, state IDLE.
